alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the 8-bit combinational ALU.
- Operand width is configurable. Operations are accepted through a valid/ready handshake.
- Result and flags come out of a 2-stage registered pipeline with full back-pressure.
- Sits between the operand-fetch logic and the result writeback path; sustains one operation per clock.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 4..32).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand bundle (a, b, opcode) is valid.
- in_ready  output  1  block can accept the bundle this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored by unary ops.
- opcode  input  4  operation select (map below).
- out_valid  output  1  result bundle is valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out  output  WIDTH  result.
- cout  output  1  carry / shifted-out bit.
- zero  output  1  out == 0.
- neg  output  1  out[WIDTH-1].
- ovf  output  1  signed overflow (ADD/SUB only, else 0).
- illegal  output  1  opcode was not in the map.

Behaviour:
- Opcode map (unchanged from the 8-bit ALU):
  - 1111 ADD: out = a+b, cout = carry out of the MSB.
  - 1110 SUB: out = a-b computed as a+~b+1; cout = carry out, so 1 means no borrow.
  - 0111 AND.
  - 0110 OR.
  - 0100 NOT: out = ~a.
- Opcodes new in this block:
  - 0101 XOR.
  - 0001 SHL: out = a<<1, cout = a[WIDTH-1].
  - 0010 SHR (logical): out = a>>1, cout = a[0].
  - 0011 PASS: out = a.
- Logic ops, NOT and PASS drive cout = 0.
- Any other opcode: out = 0, cout = 0, ovf = 0, illegal = 1. Such opcodes still flow through the pipeline and are handshaken like legal ones.
- ovf:
  - ADD: a and b have the same sign and out differs from it.
  - SUB: a and b have different signs and out's sign differs from a.
- zero and neg are always computed from the final out value, including for illegal opcodes.
- Stage 1 (s1) registers a, b and opcode when in_valid && in_ready.
- Stage 2 (s2) registers the computed out and flags when s1 advances.
- The outputs out, cout, zero, neg, ovf, illegal and out_valid come directly from s2 registers.
- Advance rules:
  - s2 may load when !s2_valid || out_ready.
  - s1 advances when s1_valid && (s2 may load).
  - in_ready = !s1_valid || (s2 may load). This is combinational from out_ready; no skid buffer.
- Latency: an accepted bundle appears on out_valid exactly 2 cycles after acceptance when out_ready is held high.
- Throughput: 1 bundle per cycle when out_ready is held high.
- Stall:
  - While out_valid && !out_ready, every s2 output holds stable.
  - With s1 also full, in_ready = 0 and s1 holds.
- Simultaneous accept and advance: s1 is reloaded in the same cycle it hands off to s2. No bubble is inserted.
- Ordering: strictly in order; no bundle is dropped or duplicated.
- Reset (asynchronous, any time including mid-stall):
  - s1_valid = 0, s2_valid = 0.
  - out = 0, cout = 0, zero = 1, neg = 0, ovf = 0, illegal = 0, out_valid = 0.
  - in_ready = 1 while rst_n is low and in the first cycle after release.
  - In-flight bundles are discarded.
- Width rules:
  - All arithmetic is WIDTH+1 bits wide internally.
  - out is the low WIDTH bits; cout is bit WIDTH.

Optional Feature:
- Macro: ALU_PIPE_MUL_EN.
- Defined:
  - Opcode 1000 is MUL: unsigned a*b, out = low WIDTH bits of the 2*WIDTH product.
  - cout = OR of the high WIDTH bits (product truncated).
  - ovf = 0, illegal = 0.
  - Latency and handshake are unchanged; the product is computed between s1 and s2.
- Not defined: opcode 1000 is illegal and follows the illegal-opcode rules. No multiplier logic is synthesised.

Test Plan:
- WIDTH=8, ADD a=FF b=FF, out_ready=1 -> 2 cycles later out=FE, cout=1, zero=0, neg=1, ovf=0.
- SUB a=00 b=01 -> out=FF, cout=0 (borrow), neg=1. SUB a=80 b=01 -> out=7F, ovf=1.
- OR CC|33 -> FF. AND CC&33 -> 00 with zero=1. NOT AA -> 55. Opcode 1001 -> out=00, illegal=1. Opcode 1000 -> illegal=1 without ALU_PIPE_MUL_EN; with it, 10*10 -> out=00, cout=1.
- Back-to-back stream of 6 ADDs, out_ready=1 -> out_valid high for 6 consecutive cycles, results in order.
- Hold out_ready=0 after 3 accepts:
  - out_valid and out held stable; in_ready=0 after s1 and s2 are full.
  - Raising out_ready drains in order with no loss or duplicate.
- Assert rst_n=0 mid-stall with both stages full -> out_valid=0, all outputs at reset values immediately (asynchronous); after release the first accepted op completes normally.
- WIDTH=16, ADD FFFF+0001 -> out=0000, cout=1, zero=1. SHL 8000 -> out=0000, cout=1.

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: s1 holds operands, s2 holds result and flags.
// Optional macro ALU_PIPE_MUL_EN adds an unsigned multiply on opcode 1000.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD  = 4'b1111;
  localparam logic [3:0] OP_SUB  = 4'b1110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0001;
  localparam logic [3:0] OP_SHR  = 4'b0010;
  localparam logic [3:0] OP_PASS = 4'b0011;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1000;
`endif

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_q, res_d;
  logic             cout_q, cout_d;
  logic             zero_q, neg_q;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;

  logic             s2_load, s1_adv, accept;
  logic [WIDTH:0]   sum_add, sum_sub;

  // in_ready looks through to out_ready; there is no skid buffer.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_load;
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready;

  assign s1_valid_d = accept ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
  assign s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;

  assign sum_add = {1'b0, a_q} + {1'b0, b_q};
  assign sum_sub = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};

`ifdef ALU_PIPE_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`endif

  always_comb begin
    res_d  = '0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    ill_d  = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_d  = sum_add[WIDTH-1:0];
        cout_d = sum_add[WIDTH];
        ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_add[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_d  = sum_sub[WIDTH-1:0];
        cout_d = sum_sub[WIDTH];
        ovf_d  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum_sub[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  res_d = a_q & b_q;
      OP_OR:   res_d = a_q | b_q;
      OP_NOT:  res_d = ~a_q;
      OP_XOR:  res_d = a_q ^ b_q;
      OP_SHL: begin
        res_d  = {a_q[WIDTH-2:0], 1'b0};
        cout_d = a_q[WIDTH-1];
      end
      OP_SHR: begin
        res_d  = {1'b0, a_q[WIDTH-1:1]};
        cout_d = a_q[0];
      end
      OP_PASS: res_d = a_q;
`ifdef ALU_PIPE_MUL_EN
      OP_MUL: begin
        res_d  = prod[WIDTH-1:0];
        cout_d = |prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= opcode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      cout_q     <= 1'b0;
      zero_q     <= 1'b1;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s1_adv) begin
        out_q  <= res_d;
        cout_q <= cout_d;
        zero_q <= (res_d == '0);
        neg_q  <= res_d[WIDTH-1];
        ovf_q  <= ovf_d;
        ill_q  <= ill_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = out_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: an 8-bit instance for function and handshake,
// a 16-bit instance for width-dependent carry and shift behaviour.
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, dout;
  logic [3:0] opcode;
  logic       cout, zero, neg, ovf, illegal;

  logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w;
  logic [15:0] a_w, b_w, dout_w;
  logic [3:0]  opcode_w;
  logic        cout_w, zero_w, neg_w, ovf_w, illegal_w;

  int n_checks = 0;
  int n_fail   = 0;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .out(dout), .cout(cout), .zero(zero), .neg(neg), .ovf(ovf), .illegal(illegal)
  );

  alu_pipe #(.WIDTH(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .a(a_w), .b(b_w), .opcode(opcode_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .out(dout_w), .cout(cout_w), .zero(zero_w), .neg(neg_w), .ovf(ovf_w), .illegal(illegal_w)
  );

  // {opcode, a, b, expected out, expected {cout,zero,neg,ovf,illegal}}
  logic [32:0] vec [14];

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; opcode = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b0; a_w = '0; b_w = '0; opcode_w = '0;
    #12;
    n_checks++;
    if ({out_valid, dout, cout, zero, neg, ovf, illegal} !== {1'b0, 8'h00, 5'b01000}) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b out=%h flags=%b, want valid=0 out=00 flags=01000",
               out_valid, dout, {cout, zero, neg, ovf, illegal});
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_checks++;
    if ({out_valid_w, dout_w, zero_w} !== {1'b0, 16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_w: got valid=%b out=%h zero=%b want 0 0000 1", out_valid_w, dout_w, zero_w);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ops();
    logic [32:0] v;
    logic [7:0]  eo;
    logic [4:0]  ef;
    for (int i = 0; i < 14; i++) begin
      v = vec[i];
      opcode = v[32:29]; a = v[28:21]; b = v[20:13];
      eo = v[12:5]; ef = v[4:0];
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL op%0d_in_ready: got %b want 1", i, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL op%0d_early_valid: got %b want 0", i, out_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, dout, cout, zero, neg, ovf, illegal} !== {1'b1, eo, ef}) begin
        n_fail++;
        $display("FAIL op%0d_result (op=%b a=%h b=%h): got valid=%b out=%h flags=%b, want valid=1 out=%h flags=%b",
                 i, v[32:29], v[28:21], v[20:13], out_valid, dout,
                 {cout, zero, neg, ovf, illegal}, eo, ef);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    opcode = 4'b1111; b = 8'h10;
    for (int t = 0; t < 8; t++) begin
      if (t < 6) begin
        in_valid = 1'b1; a = 8'(t);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_in_ready t=%0d: got %b want 1", t, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      n_checks++;
      if (t >= 1 && t <= 6) begin
        if (out_valid !== 1'b1 || dout !== 8'(8'h10 + t - 1)) begin
          n_fail++;
          $display("FAIL b2b_out t=%0d: got valid=%b out=%h want valid=1 out=%h",
                   t, out_valid, dout, 8'(8'h10 + t - 1));
        end
      end else if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL b2b_idle t=%0d: got valid=%b want 0", t, out_valid);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    out_ready = 1'b1; opcode = 4'b1111; b = 8'h01;
    in_valid = 1'b1; a = 8'h20;
    @(posedge clk); #1;
    a = 8'h21;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || dout !== 8'h21) begin
      n_fail++; $display("FAIL stall_first: got valid=%b out=%h want 1 21", out_valid, dout);
    end
    a = 8'h22;
    @(posedge clk); #1;
    out_ready = 1'b0; a = 8'h23;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || dout !== 8'h22 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_enter: got valid=%b out=%h in_ready=%b want 1 22 0", out_valid, dout, in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || dout !== 8'h22 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold k=%0d: got valid=%b out=%h in_ready=%b want 1 22 0",
                 k, out_valid, dout, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || dout !== 8'h23) begin
      n_fail++; $display("FAIL drain_1: got valid=%b out=%h want 1 23", out_valid, dout);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || dout !== 8'h24) begin
      n_fail++; $display("FAIL drain_2: got valid=%b out=%h want 1 24", out_valid, dout);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0; in_valid = 1'b1;
    opcode = 4'b1111; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    opcode = 4'b1001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || dout !== 8'hFE || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_both: got valid=%b out=%h in_ready=%b want 1 fe 0", out_valid, dout, in_ready);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, dout, cout, zero, neg, ovf, illegal} !== {1'b0, 8'h00, 5'b01000} || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b out=%h flags=%b in_ready=%b want 0 00 01000 1",
               out_valid, dout, {cout, zero, neg, ovf, illegal}, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; opcode = 4'b1111; a = 8'h01; b = 8'h02;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_stale: got valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || dout !== 8'h03 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_op: got valid=%b out=%h illegal=%b want 1 03 0", out_valid, dout, illegal);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width16();
    out_ready_w = 1'b1; in_valid_w = 1'b1;
    opcode_w = 4'b1111; a_w = 16'hFFFF; b_w = 16'h0001;
    @(posedge clk); #1;
    opcode_w = 4'b0001; a_w = 16'h8000;
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    n_checks++;
    if ({out_valid_w, dout_w, cout_w, zero_w, neg_w, ovf_w, illegal_w} !== {1'b1, 16'h0000, 5'b11000}) begin
      n_fail++;
      $display("FAIL w16_add: got valid=%b out=%h flags=%b want 1 0000 11000",
               out_valid_w, dout_w, {cout_w, zero_w, neg_w, ovf_w, illegal_w});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid_w, dout_w, cout_w, zero_w, neg_w, ovf_w, illegal_w} !== {1'b1, 16'h0000, 5'b11000}) begin
      n_fail++;
      $display("FAIL w16_shl: got valid=%b out=%h flags=%b want 1 0000 11000",
               out_valid_w, dout_w, {cout_w, zero_w, neg_w, ovf_w, illegal_w});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vec[0]  = {4'b1111, 8'hFF, 8'hFF, 8'hFE, 5'b10100};
    vec[1]  = {4'b1110, 8'h00, 8'h01, 8'hFF, 5'b00100};
    vec[2]  = {4'b1110, 8'h80, 8'h01, 8'h7F, 5'b10010};
    vec[3]  = {4'b0110, 8'hCC, 8'h33, 8'hFF, 5'b00100};
    vec[4]  = {4'b0111, 8'hCC, 8'h33, 8'h00, 5'b01000};
    vec[5]  = {4'b0100, 8'hAA, 8'h00, 8'h55, 5'b00000};
    vec[6]  = {4'b0101, 8'hF0, 8'h3C, 8'hCC, 5'b00100};
    vec[7]  = {4'b0001, 8'h81, 8'h00, 8'h02, 5'b10000};
    vec[8]  = {4'b0010, 8'h81, 8'h00, 8'h40, 5'b10000};
    vec[9]  = {4'b0011, 8'h5A, 8'h00, 8'h5A, 5'b00000};
    vec[10] = {4'b1001, 8'h12, 8'h34, 8'h00, 5'b01001};
    vec[11] = {4'b1111, 8'h7F, 8'h01, 8'h80, 5'b00110};
    vec[12] = {4'b1110, 8'h05, 8'h05, 8'h00, 5'b11000};
`ifdef ALU_PIPE_MUL_EN
    vec[13] = {4'b1000, 8'h10, 8'h10, 8'h00, 5'b11000};
`else
    vec[13] = {4'b1000, 8'h10, 8'h10, 8'h00, 5'b01001};
`endif
    test_reset();
    test_ops();
    test_back_to_back();
    test_stall();
    test_reset_mid_stall();
    test_width16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
